fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

Write-side arbiter that shares the single write port of the asynchronous FIFO among NREQ requesters in the write clock domain. It grants the port to one requester at a time in round-robin order and lets the owner write a burst of up to BURST words. It drives the FIFO's increment strobe and write data, and stalls on the FIFO's registered full flag. It sits directly in front of the FIFO write-pointer/full logic and shares its clock edge.

## Interface
- NREQ, 4: number of requesters, 2..8.
- DSIZE, 8: data word width.
- BURST, 4: maximum words per grant, 1..16.

- wclk  in  1  write-domain clock; all state updates on the falling edge.
- wrst  in  1  reset, asynchronous, active-high.
- req  in  NREQ  per-requester write request; held high while the requester has a word on its lane.
- wdata_in  in  NREQ*DSIZE  requester data lanes; lane i is bits [i*DSIZE +: DSIZE].
- wfull  in  1  FIFO full flag, registered in the FIFO write domain.
- gnt  out  NREQ  one-hot registered grant; all zero when idle.
- ack  out  NREQ  one-hot; word on the owner's lane is accepted at the next falling edge.
- winc  out  1  FIFO write increment.
- wdata  out  DSIZE  FIFO write data; the owner's lane, zero when idle.
- busy  out  1  high while in GRANT.

## Operation
- State: FSM {IDLE, GRANT}; owner index ptr (clog2(NREQ) bits); word counter cnt (clog2(BURST)+1 bits).
- Reset values: FSM=IDLE, gnt=0, cnt=0, ptr=NREQ-1, so requester 0 has first priority. All outputs are 0 during reset: gnt, ack, winc, wdata, busy.
- IDLE:
  - If req is non-zero, select the first asserted req scanning from (ptr+1) mod NREQ upward with wrap.
  - Load ptr with the winner, set gnt to one-hot(winner), clear cnt, go to GRANT.
  - If req is zero, stay in IDLE.
- GRANT:
  - winc = req[ptr] & ~wfull.
  - ack = gnt when winc=1, else 0.
  - wdata = lane ptr.
- GRANT exit conditions, evaluated at each falling edge in priority order:
  - req[ptr]=0: release. No word is written; go to IDLE with gnt=0.
  - winc=1 and cnt==BURST-1: the last word is written; go to IDLE with gnt=0.
  - winc=1 otherwise: the word is written; cnt+1; stay in GRANT.
  - wfull=1: stall. cnt and gnt hold; stay in GRANT, with no timeout.
- One arbitration (IDLE) cycle always separates consecutive grants, including re-grant to the same requester.
- Round-robin fairness: after requester i releases, i has the lowest priority in the next arbitration. With all requesters busy, each requester waits at most (NREQ-1)*(BURST+1) write cycles plus stalls.
- req changes on non-owner lanes during GRANT have no effect until the next IDLE.
- cnt is never compared against values of BURST or more; it never wraps.

## Timing
- req rise to gnt: 1 falling edge, provided the FSM is in IDLE.
- gnt to first winc: 0 cycles. winc is combinational from the registered gnt/FSM, req and wfull.
- ack and winc are asserted together. The FIFO and the requester both consume the word at the same falling edge, and the requester presents its next word after that edge.
- wfull rise: winc and ack drop in the same cycle, with no word lost or duplicated. Writing resumes in the cycle after wfull falls.
- A full burst occupies BURST+1 cycles including arbitration; stalls add 1 cycle per full cycle.
- wrst assertion mid-burst: gnt, winc, ack, busy and wdata go to 0 immediately (asynchronous), and ptr returns to NREQ-1. The partially written burst is not resumed.
- wrst deassertion: first grant possible at the second falling edge after release.

## Test plan
- Single requester: NREQ=4, BURST=4, req=0001, wfull=0, lane0 = 0x10,0x11,... -> gnt=0001 after 1 edge; winc high for 4 cycles writing 0x10..0x13; 1 IDLE cycle; re-granted; the pattern repeats.
- All requesters: req=1111 held -> grant order 0,1,2,3,0. Each grant writes exactly 4 words, with exactly one IDLE cycle between grants.
- Full stall: assert wfull for 3 cycles after the 2nd word of a burst -> winc=0 and ack=0 for those 3 cycles, cnt holds, gnt is unchanged. The 3rd and 4th words follow with no loss or duplication; the FIFO receives 4 words total.
- Early release: owner 2 drops req after 1 word while req=0110 -> 1 word written; gnt goes to 0100 → 0000 → 0010 (requester 1 granted next), not back to 2.
- Reset mid-burst: assert wrst during the 2nd word of requester 1 -> gnt, winc, ack all 0 immediately. After release with req=0011, requester 0 is granted first.
- BURST=1 configuration with req=1010 -> alternating single-word grants 1,3,1,3, each separated by one IDLE cycle.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
//
// Shares the single write port of the asynchronous FIFO among NREQ requesters
// living in the write clock domain. Ownership is handed out round-robin, one
// requester at a time, for a burst of at most BURST words. All state changes
// on the falling edge of wclk, the same edge the FIFO write-pointer logic uses.
//
// Parameters
//   NREQ   number of requesters (2..8)
//   DSIZE  data word width
//   BURST  maximum words written per grant (1..16)
//
// Ports
//   wclk      in   write-domain clock, falling-edge active
//   wrst      in   asynchronous, active-high reset
//   req       in   per-requester request, high while a word sits on its lane
//   wdata_in  in   requester lanes, lane i = wdata_in[i*DSIZE +: DSIZE]
//   wfull     in   FIFO full flag (registered in the write domain)
//   gnt       out  one-hot registered grant, zero when idle
//   ack       out  one-hot, owner's word is consumed at the next falling edge
//   winc      out  FIFO write increment
//   wdata     out  FIFO write data (owner's lane, zero when idle)
//   busy      out  high while a grant is active (exposes the FSM state)
//
// Handshake: a word moves from requester to FIFO at a falling edge exactly
// when winc is high in the cycle before it. winc = owner req & ~wfull, and ack
// mirrors gnt in that same cycle, so the requester and the FIFO both consume
// the word at the same edge; the requester presents its next word afterwards.
// A requester that drops req while owning the port gives the port up without
// writing.
// -----------------------------------------------------------------------------
module fifo_wr_arbiter #(
  parameter int NREQ  = 4,
  parameter int DSIZE = 8,
  parameter int BURST = 4
) (
  input  logic                  wclk,
  input  logic                  wrst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*DSIZE-1:0] wdata_in,
  input  logic                  wfull,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       ack,
  output logic                  winc,
  output logic [DSIZE-1:0]      wdata,
  output logic                  busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(BURST) + 1;

  localparam logic [PW-1:0] PTR_RST  = PW'(NREQ - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(BURST - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t            state_q;
  logic [PW-1:0]     ptr_q;
  logic [CW-1:0]     cnt_q;
  logic [NREQ-1:0]   gnt_q;
  logic              armed_q;

  logic              in_grant;
  logic              owner_req;
  logic              win_found;
  logic [PW-1:0]     win_idx;
  logic [PW-1:0]     cand;
  logic [DSIZE-1:0]  lanes [NREQ];

  // Split the flat lane bus so the owner lane is a plain array lookup.
  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    assign lanes[i] = wdata_in[i*DSIZE +: DSIZE];
  end

  assign in_grant  = (state_q == S_GRANT);
  assign owner_req = req[ptr_q];

  assign winc  = in_grant & owner_req & ~wfull;
  assign ack   = winc ? gnt_q : '0;
  assign gnt   = gnt_q;
  assign wdata = in_grant ? lanes[ptr_q] : '0;
  assign busy  = in_grant;

  // Round-robin pick: scan upward from the requester after the last owner,
  // wrapping, so the last owner ends up with the lowest priority.
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_q;
    cand      = ptr_q;
    for (int k = 1; k <= NREQ; k++) begin
      cand = PW'((int'(ptr_q) + k) % NREQ);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // armed_q holds off arbitration for one falling edge after reset release,
  // so the first grant can land on the second falling edge at the earliest.
  always_ff @(negedge wclk or posedge wrst) begin
    if (wrst) begin
      state_q <= S_IDLE;
      ptr_q   <= PTR_RST;
      cnt_q   <= '0;
      gnt_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      armed_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (armed_q && win_found) begin
            ptr_q   <= win_idx;
            gnt_q   <= NREQ'(1) << win_idx;
            cnt_q   <= '0;
            state_q <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (!owner_req) begin
            // Owner released: nothing written, back to arbitration.
            gnt_q   <= '0;
            state_q <= S_IDLE;
          end else if (winc) begin
            if (cnt_q == CNT_LAST) begin
              gnt_q   <= '0;
              state_q <= S_IDLE;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          // Otherwise the FIFO is full: hold grant and count, no timeout.
        end
        default: begin
          gnt_q   <= '0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_arbiter
//
// Two arbiters share clock and reset: dev 0 with BURST=4, dev 1 with BURST=1,
// both NREQ=4, DSIZE=8. Requesters are queues of words; a requester raises req
// while it is enabled and has a word, and pops a word whenever the arbiter
// acks it. A reference model (owner / last owner / words written) predicts
// every output each cycle. Inputs change and outputs are sampled just after
// the rising edge, half a period away from the active falling edge.
// -----------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

  localparam int NREQ  = 4;
  localparam int DSIZE = 8;
  localparam int W     = 2*NREQ + 1 + DSIZE + 1;

  // ---------------- clock / reset ----------------
  logic wclk = 1'b0;
  logic wrst = 1'b1;
  always #5 wclk = ~wclk;

  // ---------------- DUT wiring ----------------
  logic [NREQ-1:0]       req_v   [2];
  logic [NREQ*DSIZE-1:0] lanes_v [2];
  logic                  wfull_v [2];

  logic [NREQ-1:0]       req_a, req_b, gnt_a, gnt_b, ack_a, ack_b;
  logic [NREQ*DSIZE-1:0] lanes_a, lanes_b;
  logic                  wfull_a, wfull_b, winc_a, winc_b, busy_a, busy_b;
  logic [DSIZE-1:0]      wdata_a, wdata_b;

  assign req_a   = req_v[0];
  assign req_b   = req_v[1];
  assign lanes_a = lanes_v[0];
  assign lanes_b = lanes_v[1];
  assign wfull_a = wfull_v[0];
  assign wfull_b = wfull_v[1];

  fifo_wr_arbiter #(.NREQ(NREQ), .DSIZE(DSIZE), .BURST(4)) dut_a (
    .wclk(wclk), .wrst(wrst), .req(req_a), .wdata_in(lanes_a), .wfull(wfull_a),
    .gnt(gnt_a), .ack(ack_a), .winc(winc_a), .wdata(wdata_a), .busy(busy_a)
  );

  fifo_wr_arbiter #(.NREQ(NREQ), .DSIZE(DSIZE), .BURST(1)) dut_b (
    .wclk(wclk), .wrst(wrst), .req(req_b), .wdata_in(lanes_b), .wfull(wfull_b),
    .gnt(gnt_b), .ack(ack_b), .winc(winc_b), .wdata(wdata_b), .busy(busy_b)
  );

  // ---------------- bench state ----------------
  logic [NREQ-1:0]  hold     [2];
  logic             full_ctl [2];
  logic             release_req;
  logic [DSIZE-1:0] src_q [2*NREQ][$];
  logic [DSIZE-1:0] exp_q [2][$];
  logic [DSIZE-1:0] got_q [2][$];
  int               glog  [2][$];
  logic [NREQ-1:0]  prev_gnt [2];

  logic [W-1:0]     obs_v [2];
  logic [W-1:0]     exp_v [2];
  logic [NREQ-1:0]  obs_gnt [2];
  logic [NREQ-1:0]  obs_ack [2];
  logic             obs_winc [2];
  logic [DSIZE-1:0] obs_wd [2];
  logic             obs_busy [2];

  // reference model
  int m_own  [2];
  int m_last [2];
  int m_cnt  [2];
  bit m_arm  [2];
  int m_burst [2];

  int n_tests;
  int n_fail;

  // ---------------- driver tasks ----------------
  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_own[d]  = -1;
      m_last[d] = NREQ - 1;
      m_cnt[d]  = 0;
      m_arm[d]  = 1'b0;
    end
  endtask

  task automatic clear_all();
    for (int k = 0; k < 2*NREQ; k++) src_q[k].delete();
    for (int d = 0; d < 2; d++) begin
      exp_q[d].delete();
      got_q[d].delete();
      glog[d].delete();
      hold[d]     = '0;
      full_ctl[d] = 1'b0;
    end
  endtask

  // Apply this cycle's inputs, then capture DUT outputs and model predictions.
  task automatic drive();
    logic [NREQ-1:0]  e_gnt, e_ack;
    logic             e_winc;
    logic [DSIZE-1:0] e_wd;
    int               k;
    @(posedge wclk);
    if (release_req) begin
      wrst        = 1'b0;
      release_req = 1'b0;
    end
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < NREQ; i++) begin
        k = d*NREQ + i;
        req_v[d][i] = hold[d][i] && (src_q[k].size() > 0);
        lanes_v[d][i*DSIZE +: DSIZE] = (src_q[k].size() > 0) ? src_q[k][0] : '0;
      end
      wfull_v[d] = full_ctl[d];
    end
    #1;
    obs_gnt[0] = gnt_a;  obs_ack[0] = ack_a;  obs_winc[0] = winc_a;
    obs_wd[0]  = wdata_a; obs_busy[0] = busy_a;
    obs_gnt[1] = gnt_b;  obs_ack[1] = ack_b;  obs_winc[1] = winc_b;
    obs_wd[1]  = wdata_b; obs_busy[1] = busy_b;
    for (int d = 0; d < 2; d++) begin
      obs_v[d] = {obs_gnt[d], obs_ack[d], obs_winc[d], obs_wd[d], obs_busy[d]};
      e_gnt  = '0;
      e_winc = 1'b0;
      e_wd   = '0;
      if (m_own[d] >= 0) begin
        e_gnt[m_own[d]] = 1'b1;
        e_winc = req_v[d][m_own[d]] && !wfull_v[d];
        e_wd   = lanes_v[d][m_own[d]*DSIZE +: DSIZE];
      end
      e_ack    = e_winc ? e_gnt : '0;
      exp_v[d] = {e_gnt, e_ack, e_winc, e_wd, (m_own[d] >= 0)};
    end
  endtask

  // Log what was written, let requesters consume acked words, advance model.
  task automatic commit();
    int w;
    bit found;
    for (int d = 0; d < 2; d++) begin
      if (obs_winc[d]) got_q[d].push_back(obs_wd[d]);
      if (exp_v[d][DSIZE+1]) exp_q[d].push_back(exp_v[d][DSIZE:1]);
      if (obs_gnt[d] != '0 && prev_gnt[d] == '0)
        for (int i = 0; i < NREQ; i++) if (obs_gnt[d][i]) glog[d].push_back(i);
      prev_gnt[d] = obs_gnt[d];
      for (int i = 0; i < NREQ; i++)
        if (obs_ack[d][i] === 1'b1 && src_q[d*NREQ+i].size() > 0)
          void'(src_q[d*NREQ+i].pop_front());

      if (wrst) begin
        m_own[d] = -1; m_last[d] = NREQ - 1; m_cnt[d] = 0; m_arm[d] = 1'b0;
      end else begin
        if (m_own[d] < 0) begin
          if (m_arm[d]) begin
            found = 1'b0;
            for (int s = 1; s <= NREQ; s++) begin
              w = (m_last[d] + s) % NREQ;
              if (!found && req_v[d][w]) begin
                found = 1'b1; m_own[d] = w; m_last[d] = w; m_cnt[d] = 0;
              end
            end
          end
        end else if (!req_v[d][m_own[d]]) begin
          m_own[d] = -1;
        end else if (!wfull_v[d]) begin
          m_cnt[d]++;
          if (m_cnt[d] == m_burst[d]) m_own[d] = -1;
        end
        m_arm[d] = 1'b1;
      end
    end
  endtask

  // Hold reset for two edges; release happens at the start of the next drive.
  task automatic reset_seq();
    clear_all();
    wrst = 1'b1;
    model_reset();
    repeat (2) begin drive(); commit(); end
    release_req = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    clear_all();
    wrst = 1'b1;
    model_reset();
    repeat (2) begin
      drive();
      for (int d = 0; d < 2; d++) begin
        n_tests++;
        if (obs_v[d] !== '0) begin
          n_fail++;
          $display("FAIL reset_outputs dev%0d: got %h, expected 0", d, obs_v[d]);
        end
      end
      commit();
    end
    src_q[0].push_back(8'hA0);
    src_q[0].push_back(8'hA1);
    hold[0] = 4'b0001;
    release_req = 1'b1;
    for (int c = 0; c < 7; c++) begin
      drive();
      for (int d = 0; d < 2; d++) begin
        n_tests++;
        if (obs_v[d] !== exp_v[d]) begin
          n_fail++;
          $display("FAIL reset_cycle dev%0d @%0t: got %h, expected %h", d, $time, obs_v[d], exp_v[d]);
        end
      end
      if (c == 1) begin
        n_tests++;
        if (obs_gnt[0] !== 4'b0000) begin
          n_fail++;
          $display("FAIL reset_first_edge_nogrant: got %b, expected 0000", obs_gnt[0]);
        end
      end
      if (c == 2) begin
        n_tests++;
        if (obs_gnt[0] !== 4'b0001) begin
          n_fail++;
          $display("FAIL reset_second_edge_grant: got %b, expected 0001", obs_gnt[0]);
        end
      end
      commit();
    end
  endtask

  task automatic test_single();
    clear_all();
    for (int j = 0; j < 8; j++) src_q[0].push_back(DSIZE'(8'h10 + j));
    hold[0] = 4'b0001;
    for (int c = 0; c < 13; c++) begin
      drive();
      for (int d = 0; d < 2; d++) begin
        n_tests++;
        if (obs_v[d] !== exp_v[d]) begin
          n_fail++;
          $display("FAIL single_cycle dev%0d @%0t: got %h, expected %h", d, $time, obs_v[d], exp_v[d]);
        end
      end
      if (c == 1) begin
        n_tests++;
        if (obs_gnt[0] !== 4'b0001) begin
          n_fail++;
          $display("FAIL single_grant_latency: got %b, expected 0001", obs_gnt[0]);
        end
      end
      commit();
    end
    n_tests++;
    if (got_q[0].size() != 8) begin
      n_fail++;
      $display("FAIL single_word_count: got %0d, expected 8", got_q[0].size());
    end
    for (int j = 0; j < 8 && j < got_q[0].size(); j++) begin
      n_tests++;
      if (got_q[0][j] !== DSIZE'(8'h10 + j)) begin
        n_fail++;
        $display("FAIL single_word%0d: got %h, expected %h", j, got_q[0][j], 8'h10 + j);
      end
    end
    n_tests++;
    if (glog[0].size() != 2) begin
      n_fail++;
      $display("FAIL single_regrant: got %0d grants, expected 2", glog[0].size());
    end
  endtask

  task automatic test_all();
    logic [DSIZE-1:0] words [NREQ][8];
    int exp_order [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    int idx;
    reset_seq();
    for (int i = 0; i < NREQ; i++)
      for (int j = 0; j < 8; j++) begin
        words[i][j] = DSIZE'($urandom_range(0, 255));
        src_q[i].push_back(words[i][j]);
      end
    hold[0] = 4'b1111;
    for (int c = 0; c < 46; c++) begin
      drive();
      for (int d = 0; d < 2; d++) begin
        n_tests++;
        if (obs_v[d] !== exp_v[d]) begin
          n_fail++;
          $display("FAIL all_cycle dev%0d @%0t: got %h, expected %h", d, $time, obs_v[d], exp_v[d]);
        end
      end
      commit();
    end
    n_tests++;
    if (glog[0].size() != 8) begin
      n_fail++;
      $display("FAIL all_grant_count: got %0d, expected 8", glog[0].size());
    end
    for (int g = 0; g < 8 && g < glog[0].size(); g++) begin
      n_tests++;
      if (glog[0][g] != exp_order[g]) begin
        n_fail++;
        $display("FAIL all_grant_order[%0d]: got %0d, expected %0d", g, glog[0][g], exp_order[g]);
      end
    end
    n_tests++;
    if (got_q[0].size() != 32) begin
      n_fail++;
      $display("FAIL all_word_count: got %0d, expected 32", got_q[0].size());
    end
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NREQ; i++)
        for (int j = 0; j < 4; j++) begin
          idx = r*16 + i*4 + j;
          if (idx < got_q[0].size()) begin
            n_tests++;
            if (got_q[0][idx] !== words[i][r*4+j]) begin
              n_fail++;
              $display("FAIL all_word%0d: got %h, expected %h", idx, got_q[0][idx], words[i][r*4+j]);
            end
          end
        end
  endtask

  task automatic test_full_stall();
    logic [DSIZE-1:0] words [4];
    clear_all();
    for (int j = 0; j < 4; j++) begin
      words[j] = DSIZE'($urandom_range(0, 255));
      src_q[0].push_back(words[j]);
    end
    hold[0] = 4'b0001;
    for (int c = 0; c < 10; c++) begin
      full_ctl[0] = (c >= 3 && c <= 5);
      drive();
      for (int d = 0; d < 2; d++) begin
        n_tests++;
        if (obs_v[d] !== exp_v[d]) begin
          n_fail++;
          $display("FAIL stall_cycle dev%0d @%0t: got %h, expected %h", d, $time, obs_v[d], exp_v[d]);
        end
      end
      if (c >= 3 && c <= 5) begin
        n_tests++;
        if ({obs_winc[0], obs_ack[0], obs_gnt[0]} !== {1'b0, 4'b0000, 4'b0001}) begin
          n_fail++;
          $display("FAIL stall_hold c%0d: got winc=%b ack=%b gnt=%b, expected 0 0000 0001",
                   c, obs_winc[0], obs_ack[0], obs_gnt[0]);
        end
      end
      commit();
    end
    n_tests++;
    if (got_q[0].size() != 4) begin
      n_fail++;
      $display("FAIL stall_word_count: got %0d, expected 4", got_q[0].size());
    end
    for (int j = 0; j < 4 && j < got_q[0].size(); j++) begin
      n_tests++;
      if (got_q[0][j] !== words[j]) begin
        n_fail++;
        $display("FAIL stall_word%0d: got %h, expected %h", j, got_q[0][j], words[j]);
      end
    end
  endtask

  task automatic test_early_release();
    logic [DSIZE-1:0] w2, w10, w11;
    logic [NREQ-1:0] exp_g [5] = '{4'b0000, 4'b0100, 4'b0100, 4'b0000, 4'b0010};
    clear_all();
    w2  = DSIZE'($urandom_range(0, 255));
    w10 = DSIZE'($urandom_range(0, 255));
    w11 = DSIZE'($urandom_range(0, 255));
    src_q[2].push_back(w2);
    repeat (3) src_q[2].push_back(DSIZE'($urandom_range(0, 255)));
    src_q[1].push_back(w10);
    src_q[1].push_back(w11);
    for (int c = 0; c < 9; c++) begin
      hold[0] = (c == 0) ? 4'b0100 : (c == 1) ? 4'b0110 : 4'b0010;
      drive();
      for (int d = 0; d < 2; d++) begin
        n_tests++;
        if (obs_v[d] !== exp_v[d]) begin
          n_fail++;
          $display("FAIL release_cycle dev%0d @%0t: got %h, expected %h", d, $time, obs_v[d], exp_v[d]);
        end
      end
      if (c < 5) begin
        n_tests++;
        if (obs_gnt[0] !== exp_g[c]) begin
          n_fail++;
          $display("FAIL release_gnt c%0d: got %b, expected %b", c, obs_gnt[0], exp_g[c]);
        end
      end
      commit();
    end
    n_tests++;
    if (got_q[0].size() != 3 || got_q[0][0] !== w2 || got_q[0][1] !== w10 || got_q[0][2] !== w11) begin
      n_fail++;
      $display("FAIL release_words: got %0d words, expected %h %h %h", got_q[0].size(), w2, w10, w11);
    end
  endtask

  task automatic test_random();
    int k;
    clear_all();
    for (int c = 0; c < 300; c++) begin
      for (int d = 0; d < 2; d++) begin
        for (int i = 0; i < NREQ; i++) begin
          k = d*NREQ + i;
          if (src_q[k].size() == 0 && $urandom_range(0, 3) == 0)
            repeat ($urandom_range(1, 6)) src_q[k].push_back(DSIZE'($urandom_range(0, 255)));
          hold[d][i] = ($urandom_range(0, 9) != 0);
        end
        full_ctl[d] = ($urandom_range(0, 3) == 0);
      end
      drive();
      for (int d = 0; d < 2; d++) begin
        n_tests++;
        if (obs_v[d] !== exp_v[d]) begin
          n_fail++;
          $display("FAIL random_cycle dev%0d @%0t: got %h, expected %h", d, $time, obs_v[d], exp_v[d]);
        end
      end
      commit();
    end
    for (int d = 0; d < 2; d++) begin
      hold[d] = '0;
      full_ctl[d] = 1'b0;
    end
    repeat (3) begin
      drive();
      for (int d = 0; d < 2; d++) begin
        n_tests++;
        if (obs_v[d] !== exp_v[d]) begin
          n_fail++;
          $display("FAIL random_drain dev%0d @%0t: got %h, expected %h", d, $time, obs_v[d], exp_v[d]);
        end
      end
      commit();
    end
    for (int d = 0; d < 2; d++) begin
      n_tests++;
      if (got_q[d] != exp_q[d]) begin
        n_fail++;
        $display("FAIL random_stream dev%0d: got %0d words, expected %0d words (contents differ)",
                 d, got_q[d].size(), exp_q[d].size());
      end
    end
  endtask

  task automatic test_burst1();
    logic [DSIZE-1:0] s1 [2], s3 [2];
    int exp_order [4] = '{1, 3, 1, 3};
    reset_seq();
    for (int j = 0; j < 2; j++) begin
      s1[j] = DSIZE'($urandom_range(0, 255));
      s3[j] = DSIZE'($urandom_range(0, 255));
      src_q[NREQ+1].push_back(s1[j]);
      src_q[NREQ+3].push_back(s3[j]);
    end
    hold[1] = 4'b1010;
    for (int c = 0; c < 12; c++) begin
      drive();
      for (int d = 0; d < 2; d++) begin
        n_tests++;
        if (obs_v[d] !== exp_v[d]) begin
          n_fail++;
          $display("FAIL burst1_cycle dev%0d @%0t: got %h, expected %h", d, $time, obs_v[d], exp_v[d]);
        end
      end
      commit();
    end
    n_tests++;
    if (glog[1].size() != 4) begin
      n_fail++;
      $display("FAIL burst1_grant_count: got %0d, expected 4", glog[1].size());
    end
    for (int g = 0; g < 4 && g < glog[1].size(); g++) begin
      n_tests++;
      if (glog[1][g] != exp_order[g]) begin
        n_fail++;
        $display("FAIL burst1_order[%0d]: got %0d, expected %0d", g, glog[1][g], exp_order[g]);
      end
    end
    n_tests++;
    if (got_q[1].size() != 4 || got_q[1][0] !== s1[0] || got_q[1][1] !== s3[0]
        || got_q[1][2] !== s1[1] || got_q[1][3] !== s3[1]) begin
      n_fail++;
      $display("FAIL burst1_words: got %0d words, expected %h %h %h %h",
               got_q[1].size(), s1[0], s3[0], s1[1], s3[1]);
    end
  endtask

  task automatic test_reset_mid();
    clear_all();
    for (int j = 0; j < 8; j++) src_q[1].push_back(DSIZE'($urandom_range(0, 255)));
    hold[0] = 4'b0010;
    for (int c = 0; c < 3; c++) begin
      drive();
      for (int d = 0; d < 2; d++) begin
        n_tests++;
        if (obs_v[d] !== exp_v[d]) begin
          n_fail++;
          $display("FAIL midrst_cycle dev%0d @%0t: got %h, expected %h", d, $time, obs_v[d], exp_v[d]);
        end
      end
      if (c == 2) begin
        n_tests++;
        if (obs_winc[0] !== 1'b1) begin
          n_fail++;
          $display("FAIL midrst_second_word: got winc=%b, expected 1", obs_winc[0]);
        end
      end
      if (c < 2) commit();
    end
    // Reset lands in the middle of the second word, before its edge.
    wrst = 1'b1;
    #1;
    n_tests++;
    if ({gnt_a, ack_a, winc_a, busy_a, wdata_a} !== '0) begin
      n_fail++;
      $display("FAIL midrst_async: got gnt=%b ack=%b winc=%b busy=%b wdata=%h, expected all 0",
               gnt_a, ack_a, winc_a, busy_a, wdata_a);
    end
    model_reset();
    got_q[0].delete();
    exp_q[0].delete();
    glog[0].delete();
    repeat (4) src_q[0].push_back(DSIZE'($urandom_range(0, 255)));
    hold[0] = 4'b0011;
    drive();
    commit();
    release_req = 1'b1;
    for (int c = 0; c < 24; c++) begin
      drive();
      for (int d = 0; d < 2; d++) begin
        n_tests++;
        if (obs_v[d] !== exp_v[d]) begin
          n_fail++;
          $display("FAIL midrst_after dev%0d @%0t: got %h, expected %h", d, $time, obs_v[d], exp_v[d]);
        end
      end
      commit();
    end
    n_tests++;
    if (glog[0].size() < 2 || glog[0][0] != 0 || glog[0][1] != 1) begin
      n_fail++;
      $display("FAIL midrst_first_owner: got %0d grants (first %0d), expected 0 then 1",
               glog[0].size(), (glog[0].size() > 0) ? glog[0][0] : -1);
    end
    n_tests++;
    if (got_q[0].size() != 11) begin
      n_fail++;
      $display("FAIL midrst_word_count: got %0d, expected 11", got_q[0].size());
    end
  endtask

  // ---------------- main sequence + report ----------------
  initial begin
    n_tests     = 0;
    n_fail      = 0;
    release_req = 1'b0;
    m_burst[0]  = 4;
    m_burst[1]  = 1;
    for (int d = 0; d < 2; d++) begin
      req_v[d]    = '0;
      lanes_v[d]  = '0;
      wfull_v[d]  = 1'b0;
      prev_gnt[d] = '0;
    end
    clear_all();
    model_reset();

    test_reset();
    test_single();
    test_all();
    test_full_stall();
    test_early_release();
    test_random();
    test_burst1();
    test_reset_mid();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
